// File: rtl/demux32_05_buf_pkg.sv
// Shared types and constants for the 5-lane 32-bit write-side demux.
package demux_pkg;

  localparam int unsigned LANES  = 5;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef logic [SEL_W-1:0]  lane_sel_t;
  typedef logic [DATA_W-1:0] word_t;

  // Select codes at or above this value have no lane behind them.
  localparam lane_sel_t SEL_ILLEGAL_MIN = 3'd5;

  function automatic logic sel_is_legal(lane_sel_t sel);
    return sel < SEL_ILLEGAL_MIN;
  endfunction

endpackage

// File: rtl/demux32_05_buf_if.sv
// Producer and consumer handshake bundle for demux32_05_buf.
// The producer side is the word source; the lane outputs feed five consumers.
interface demux32_05_buf_if;

  demux_pkg::lane_sel_t              signal;
  logic                              in_valid;
  logic                              in_ready;
  demux_pkg::word_t                  data_In;
  logic [demux_pkg::LANES-1:0]       out_valid;
  logic [demux_pkg::LANES-1:0]       out_ready;
  demux_pkg::word_t                  data_Out_0;
  demux_pkg::word_t                  data_Out_1;
  demux_pkg::word_t                  data_Out_2;
  demux_pkg::word_t                  data_Out_3;
  demux_pkg::word_t                  data_Out_4;

  // Environment side: drives the word and the consumer readies.
  modport master (
    output signal, in_valid, data_In, out_ready,
    input  in_ready, out_valid, data_Out_0, data_Out_1, data_Out_2, data_Out_3, data_Out_4
  );

  // Demux side.
  modport slave (
    input  signal, in_valid, data_In, out_ready,
    output in_ready, out_valid, data_Out_0, data_Out_1, data_Out_2, data_Out_3, data_Out_4
  );

endinterface

// File: rtl/demux32_05_buf_lane.sv
// One-entry holding register with valid flag. Flush clears only the valid flag;
// the data word, like after a drain, keeps its last value.
module demux_lane
  import demux_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  flush_i,
  input  logic  load_i,
  input  logic  ready_i,
  input  word_t data_i,
  output logic  valid_o,
  output word_t data_o
);

  logic  valid_q, valid_d;
  word_t data_q, data_d;

  // Next state: drain empties, load fills (load wins, giving same-cycle refill).
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      if (valid_q && ready_i) valid_d = 1'b0;
      if (load_i) begin
        valid_d = 1'b1;
        data_d  = data_i;
      end
    end
  end

  // Lane state register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/demux32_05_buf.sv
// Steers one 32-bit word to one of five buffered lanes; selects 5..7 are dropped
// and flagged on err_sel. Optional statistics counters behind DEMUX_STATS_EN.
module demux32_05_buf
  import demux_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  demux32_05_buf_if.slave  bus,
  output logic             err_sel,
  output logic [CNT_W-1:0] acc_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  logic [LANES-1:0] sel_oh;
  logic [LANES-1:0] load;
  logic [LANES-1:0] lane_valid;
  word_t            lane_data [LANES];
  logic             in_ready;
  logic             accept;
  logic             err_q, err_d;

  // Select decode and ready: only a full, non-draining selected lane stalls.
  always_comb begin
    sel_oh = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (bus.signal == lane_sel_t'(i)) sel_oh[i] = 1'b1;
    end
    in_ready = !flush && !(|(sel_oh & lane_valid & ~bus.out_ready));
    accept   = bus.in_valid && in_ready;
    // Gate with accept so an idle (possibly X) select never reaches the lanes.
    load     = accept ? sel_oh : '0;
    err_d    = accept && !sel_is_legal(bus.signal);
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .flush_i (flush),
      .load_i  (load[g]),
      .ready_i (bus.out_ready[g]),
      .data_i  (bus.data_In),
      .valid_o (lane_valid[g]),
      .data_o  (lane_data[g])
    );
  end

  // Illegal-select pulse register.
  always_ff @(posedge clk) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] acc_q, acc_d, drop_q, drop_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    acc_d  = acc_q;
    drop_d = drop_q;
    if (accept && sel_is_legal(bus.signal) && (acc_q != '1)) acc_d = acc_q + CNT_W'(1);
    if (err_d && (drop_q != '1))                             drop_d = drop_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_q  <= '0;
      drop_q <= '0;
    end else begin
      acc_q  <= acc_d;
      drop_q <= drop_d;
    end
  end

  assign acc_cnt  = acc_q;
  assign drop_cnt = drop_q;
`else
  assign acc_cnt  = '0;
  assign drop_cnt = '0;
`endif

  assign err_sel        = err_q;
  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = lane_valid;
  assign bus.data_Out_0 = lane_data[0];
  assign bus.data_Out_1 = lane_data[1];
  assign bus.data_Out_2 = lane_data[2];
  assign bus.data_Out_3 = lane_data[3];
  assign bus.data_Out_4 = lane_data[4];

endmodule

// File: tb/tb_demux32_05_buf.sv
// Self-checking bench for demux32_05_buf: directed scenarios pinned with literal
// expectations, then randomized traffic checked against a lane-array model.
module tb_demux32_05_buf;
  import demux_pkg::*;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             err_sel;
  logic [CNT_W-1:0] acc_cnt;
  logic [CNT_W-1:0] drop_cnt;

  demux32_05_buf_if bus ();

  demux32_05_buf #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .bus      (bus),
    .err_sel  (err_sel),
    .acc_cnt  (acc_cnt),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: what each consumer should currently see.
  bit          m_v [LANES];
  word_t       m_d [LANES];
  bit          m_err;
  int unsigned m_acc, m_drop;
  int          nvec = 0;
  int          nerr = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic word_t dut_word(input int i);
    case (i)
      0:       return bus.data_Out_0;
      1:       return bus.data_Out_1;
      2:       return bus.data_Out_2;
      3:       return bus.data_Out_3;
      default: return bus.data_Out_4;
    endcase
  endfunction

  function automatic bit model_ready(input bit fl, input lane_sel_t s, input logic [4:0] ordy);
    if (fl) return 1'b0;
    if (int'(s) >= LANES) return 1'b1;
    return !m_v[s] || ordy[s];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = '0;
    end
    m_err  = 1'b0;
    m_acc  = 0;
    m_drop = 0;
  endtask

  task automatic compare_all();
    logic [LANES-1:0] ev;
    for (int i = 0; i < LANES; i++) ev[i] = m_v[i];
    chk("out_valid", 64'(bus.out_valid), 64'(ev));
    for (int i = 0; i < LANES; i++) chk($sformatf("data_Out_%0d", i), 64'(dut_word(i)), 64'(m_d[i]));
    chk("err_sel", 64'(err_sel), 64'(m_err));
`ifdef DEMUX_STATS_EN
    chk("acc_cnt", 64'(acc_cnt), 64'(m_acc));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
`else
    chk("acc_cnt", 64'(acc_cnt), 64'd0);
    chk("drop_cnt", 64'(drop_cnt), 64'd0);
`endif
  endtask

  task automatic drive(input bit rn, input bit fl, input bit iv, input lane_sel_t s,
                       input word_t d, input logic [4:0] ordy);
    reset_n       = rn;
    flush         = fl;
    bus.in_valid  = iv;
    bus.signal    = s;
    bus.data_In   = d;
    bus.out_ready = ordy;
  endtask

  // One clock cycle: drive at negedge, check in_ready, advance model, check outputs.
  task automatic cyc(input bit rn, input bit fl, input bit iv, input lane_sel_t s,
                     input word_t d, input logic [4:0] ordy);
    bit rdy, acc;
    drive(rn, fl, iv, s, d, ordy);
    #1;
    rdy = model_ready(fl, s, ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    if (!rn) begin
      model_clear();
    end else if (fl) begin
      for (int i = 0; i < LANES; i++) m_v[i] = 1'b0;
      m_err = 1'b0;
    end else begin
      acc = iv && rdy;
      for (int i = 0; i < LANES; i++) if (m_v[i] && ordy[i]) m_v[i] = 1'b0;
      m_err = acc && (int'(s) >= LANES);
      if (acc && int'(s) < LANES) begin
        m_v[s] = 1'b1;
        m_d[s] = d;
        if (m_acc < CNT_MAX) m_acc++;
      end
      if (m_err && m_drop < CNT_MAX) m_drop++;
    end
    @(posedge clk);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic [4:0] ev;
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    model_clear();
    compare_all();

    // 1: single word into lane 2.
    cyc(1, 0, 1, 3'd2, 32'hDEADBEEF, 5'b00000);
    chk("t1_valid", 64'(bus.out_valid), 64'h04);
    chk("t1_data2", 64'(bus.data_Out_2), 64'hDEADBEEF);
    chk("t1_data0", 64'(bus.data_Out_0), 64'h0);

    // 2: full lane 0 stalls the producer until its consumer drains.
    cyc(1, 0, 1, 3'd0, 32'h11111111, 5'b00000);
    drive(1, 0, 1, 3'd0, 32'h22222222, 5'b00000);
    #1 chk("t2_stall", 64'(bus.in_ready), 64'h0);
    cyc(1, 0, 1, 3'd0, 32'h22222222, 5'b00000);
    chk("t2_held", 64'(bus.data_Out_0), 64'h11111111);
    drive(1, 0, 1, 3'd0, 32'h22222222, 5'b00001);
    #1 chk("t2_pass", 64'(bus.in_ready), 64'h1);
    cyc(1, 0, 1, 3'd0, 32'h22222222, 5'b00001);
    chk("t2_valid0", 64'(bus.out_valid[0]), 64'h1);
    chk("t2_data0", 64'(bus.data_Out_0), 64'h22222222);

    // 3: illegal select is swallowed and flagged for one cycle.
    cyc(1, 0, 1, 3'd6, 32'h33333333, 5'b00000);
    chk("t3_err", 64'(err_sel), 64'h1);
    chk("t3_valid", 64'(bus.out_valid), 64'h05);
`ifdef DEMUX_STATS_EN
    chk("t3_drop", 64'(drop_cnt), 64'h1);
    chk("t3_acc", 64'(acc_cnt), 64'h3);
`endif
    cyc(1, 0, 0, 3'd0, 32'h0, 5'b00000);
    chk("t3_err_end", 64'(err_sel), 64'h0);

    // 4: flush beats a concurrent accept.
    cyc(1, 0, 1, 3'd1, 32'h44440001, 5'b00000);
    cyc(1, 0, 1, 3'd3, 32'h44440003, 5'b00000);
    cyc(1, 1, 1, 3'd4, 32'hAAAAAAAA, 5'b00000);
    chk("t4_valid", 64'(bus.out_valid), 64'h0);
    chk("t4_data4", 64'(bus.data_Out_4), 64'h0);

    // 5: back-to-back through all lanes with every consumer ready.
    cyc(0, 0, 0, 3'd0, 32'h0, 5'b00000);
    for (int i = 0; i < LANES; i++) begin
      cyc(1, 0, 1, lane_sel_t'(i), 32'h55550000 + 32'(i), 5'b11111);
      ev = 5'(1 << i);
      chk("t5_onehot", 64'(bus.out_valid), 64'(ev));
    end
    cyc(1, 0, 0, 3'd0, 32'h0, 5'b11111);
    chk("t5_empty", 64'(bus.out_valid), 64'h0);
    chk("t5_data3", 64'(bus.data_Out_3), 64'h55550003);
`ifdef DEMUX_STATS_EN
    chk("t5_acc", 64'(acc_cnt), 64'h5);
`endif

    // 6: reset with lanes full and a word offered.
    cyc(1, 0, 1, 3'd0, 32'h66660000, 5'b00000);
    cyc(1, 0, 1, 3'd1, 32'h66660001, 5'b00000);
    cyc(0, 0, 1, 3'd2, 32'h66660002, 5'b00000);
    chk("t6_valid", 64'(bus.out_valid), 64'h0);
    chk("t6_data0", 64'(bus.data_Out_0), 64'h0);
    chk("t6_acc", 64'(acc_cnt), 64'h0);

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom_range(0, 99) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 7), lane_sel_t'($urandom_range(0, 7)),
          word_t'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
